implication_queue: RTL and testbench

- Sits directly downstream of the sub-clause evaluator array, during Boolean constraint propagation (BCP).
- Accepts one unit-clause implication per cycle: the evaluator's unit_clause, implied_variable and new_val outputs.
- Drops duplicate implications and detects conflicting implications (the same variable implied both true and false).
- Buffers accepted implications in a FIFO; the assignment/trail stage drains them through a valid/ready handshake.

---
 rtl/implication_queue.sv | 156 +++++++++++++++
 tb/tb_implication_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/implication_queue.sv
// Implication queue between the clause evaluators and the trail stage: filters
// duplicate and conflicting unit implications and buffers the rest in a FIFO.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module implication_queue #(
    parameter int DEPTH        = 16,
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_BITS     = `MAX_VARS_BITS
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [VAR_BITS-1:0]        in_var,
    input  logic                       in_val,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [VAR_BITS-1:0]        out_var,
    output logic                       out_val,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic                       conflict,
    output logic [VAR_BITS-1:0]        conflict_var,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);
    localparam logic [31:0] NUM_VAR_U = NUM_VARIABLE;

    typedef enum logic {
        ST_RUN,
        ST_CONFLICT
    } state_t;

    state_t                  state_reg, state_next;
    logic [PTR_BITS-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [CNT_BITS-1:0]     count_reg, count_next;
    logic [VAR_BITS:0]       mem [DEPTH];
    logic [NUM_VARIABLE-1:0] pend_reg, pend_next;
    logic [NUM_VARIABLE-1:0] pval_reg, pval_next;
    logic                    conflict_reg, overflow_reg;
    logic [VAR_BITS-1:0]     conflict_var_reg;

    logic                    full, empty, head_valid, pop;
    logic [VAR_BITS-1:0]     head_var;
    logic                    head_val;
    logic                    push_req, in_range, hit, hit_val;
    logic                    drop_range, dup, conf, drop_full, enq;
    logic [NUM_VARIABLE-1:0] sel_in, set_bit, clr_bit;

    assign full       = (count_reg == DEPTH_CNT);
    assign empty      = (count_reg == '0);
    assign head_valid = (state_reg == ST_RUN) && !empty;
    assign pop        = head_valid && out_ready && !flush;
    assign {head_var, head_val} = mem[rd_ptr_reg];

    // Per-variable decode of the incoming index and of the popping head.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VARIABLE; gi++) begin : g_pend
            assign sel_in[gi]  = (in_var == VAR_BITS'(gi));
            assign set_bit[gi] = enq && sel_in[gi];
            assign clr_bit[gi] = pop && (head_var == VAR_BITS'(gi));
        end
    endgenerate

    // Classification uses only registered pend state, so a same-cycle pop of
    // the same variable still counts as pending.
    assign push_req   = in_valid && (state_reg == ST_RUN) && !flush;
    assign in_range   = (32'(in_var) < NUM_VAR_U);
    assign hit        = |(pend_reg & sel_in);
    assign hit_val    = |(pval_reg & sel_in);
    assign drop_range = push_req && !in_range;
    assign dup        = push_req && in_range && hit && (hit_val == in_val);
    assign conf       = push_req && in_range && hit && (hit_val != in_val);
    assign drop_full  = push_req && in_range && !hit && full && !pop;
    assign enq        = push_req && in_range && !hit && !(full && !pop);

    assign pend_next  = flush ? '0 : ((pend_reg & ~clr_bit) | set_bit);
    assign pval_next  = (pval_reg & ~set_bit) | (set_bit & {NUM_VARIABLE{in_val}});
    assign count_next = flush ? '0
                      : (count_reg + CNT_BITS'(enq) - CNT_BITS'(pop));

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_RUN;
        end else if (conf) begin
            state_next = ST_CONFLICT;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_RUN;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            pend_reg         <= '0;
            pval_reg         <= '0;
            conflict_reg     <= 1'b0;
            conflict_var_reg <= '0;
            overflow_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            pend_reg  <= pend_next;
            pval_reg  <= pval_next;
            if (flush) begin
                rd_ptr_reg       <= '0;
                wr_ptr_reg       <= '0;
                conflict_reg     <= 1'b0;
                conflict_var_reg <= '0;
                overflow_reg     <= 1'b0;
            end else begin
                if (enq) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
                end
                if (conf) begin
                    conflict_reg     <= 1'b1;
                    conflict_var_reg <= in_var;
                end
                if (drop_range || drop_full) begin
                    overflow_reg <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wr_ptr_reg] <= {in_var, in_val};
        end
    end

    assign in_ready     = (state_reg == ST_RUN) && (!full || (out_ready && head_valid));
    assign out_valid    = head_valid;
    assign out_var      = head_valid ? head_var : '0;
    assign out_val      = head_valid && head_val;
    assign conflict     = conflict_reg;
    assign conflict_var = conflict_var_reg;
    assign overflow     = overflow_reg;
    assign count        = count_reg;

    logic unused_dup;
    assign unused_dup = dup;

endmodule

// File: tb/tb_implication_queue.sv
// Directed bench for implication_queue: a vector table for single-cycle
// behaviour plus hand-written fill, wrap-drain and async-reset sequences.
`timescale 1ns/1ps

module tb_implication_queue;

    localparam int DEPTH = 16;
    localparam int VB    = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [VB-1:0] in_var;
    logic          in_val;
    logic          in_ready;
    logic          out_valid;
    logic [VB-1:0] out_var;
    logic          out_val;
    logic          out_ready;
    logic          flush;
    logic          conflict;
    logic [VB-1:0] conflict_var;
    logic          overflow;
    logic [4:0]    count;

    int total = 0;
    int bad   = 0;

    implication_queue #(.DEPTH(DEPTH), .NUM_VARIABLE(128), .VAR_BITS(VB)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_var(in_var), .in_val(in_val), .in_ready(in_ready),
        .out_valid(out_valid), .out_var(out_var), .out_val(out_val), .out_ready(out_ready),
        .flush(flush), .conflict(conflict), .conflict_var(conflict_var),
        .overflow(overflow), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic v; int vr; logic vl; logic ordy; logic fl;
        int cnt; logic ovalid; int ovar; logic oval; logic conf; int cvar; logic ovf;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic v, input int vr, input logic vl, input logic o,
                                input logic f, input int c, input logic ov, input int ovr,
                                input logic ovl, input logic cf, input int cv, input logic of);
        vec_t r;
        r.v = v; r.vr = vr; r.vl = vl; r.ordy = o; r.fl = f;
        r.cnt = c; r.ovalid = ov; r.ovar = ovr; r.oval = ovl; r.conf = cf; r.cvar = cv; r.ovf = of;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int vr, input logic vl, input logic o, input logic f);
        in_valid  = v;
        in_var    = VB'(vr);
        in_val    = vl;
        out_ready = o;
        flush     = f;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q_var[$];
        logic q_val[$];
        int mcount;
        int k;
        int cyc;
        logic exp_pop, exp_rdy, do_push;

        vecs[0]  = mk(1, 5,   1, 0, 0,  1, 1, 5, 1, 0, 0, 0);
        vecs[1]  = mk(1, 9,   0, 0, 0,  2, 1, 5, 1, 0, 0, 0);
        vecs[2]  = mk(1, 5,   1, 0, 0,  2, 1, 5, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0,   0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 5,   1, 0, 0,  1, 1, 5, 1, 0, 0, 0);
        vecs[5]  = mk(1, 5,   0, 0, 0,  1, 0, 0, 0, 1, 5, 0);
        vecs[6]  = mk(1, 7,   1, 0, 0,  1, 0, 0, 0, 1, 5, 0);
        vecs[7]  = mk(0, 0,   0, 1, 0,  1, 0, 0, 0, 1, 5, 0);
        vecs[8]  = mk(0, 0,   0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 5,   0, 0, 0,  1, 1, 5, 0, 0, 0, 0);
        vecs[10] = mk(0, 0,   0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 200, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
        vecs[12] = mk(0, 0,   0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(1, 3,   0, 0, 0,  1, 1, 3, 0, 0, 0, 0);
        vecs[14] = mk(1, 3,   1, 1, 0,  0, 0, 0, 0, 1, 3, 0);
        vecs[15] = mk(0, 0,   0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, 3,   0, 0, 0,  1, 1, 3, 0, 0, 0, 0);
        vecs[17] = mk(1, 3,   0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(1, 3,   1, 0, 0,  1, 1, 3, 1, 0, 0, 0);
        vecs[19] = mk(0, 0,   0, 1, 0,  0, 0, 0, 0, 0, 0, 0);

        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_overflow", int'(overflow), 0);
        #3 reset_n = 1'b1;
        step();
        chk("post_rst_count", int'(count), 0);

        // Single-cycle vectors
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].v, vecs[i].vr, vecs[i].vl, vecs[i].ordy, vecs[i].fl);
            step();
            $display("vec %0d: v=%0b var=%0d val=%0b ordy=%0b fl=%0b -> cnt=%0d ov=%0b ovar=%0d conf=%0b ovf=%0b",
                     i, vecs[i].v, vecs[i].vr, vecs[i].vl, vecs[i].ordy, vecs[i].fl,
                     count, out_valid, out_var, conflict, overflow);
            chk($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
            chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].ovalid));
            chk($sformatf("v%0d_out_var", i), int'(out_var), vecs[i].ovar);
            chk($sformatf("v%0d_out_val", i), int'(out_val), int'(vecs[i].oval));
            chk($sformatf("v%0d_conflict", i), int'(conflict), int'(vecs[i].conf));
            chk($sformatf("v%0d_overflow", i), int'(overflow), int'(vecs[i].ovf));
            if (vecs[i].conf) chk($sformatf("v%0d_conflict_var", i), int'(conflict_var), vecs[i].cvar);
        end
        idle();

        // Fill to DEPTH, overflow drop, then push accepted alongside a pop
        drive(0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, i, 1'(i % 2), 0, 0);
            step();
        end
        idle();
        #1;
        chk("full_count", int'(count), 16);
        chk("full_in_ready", int'(in_ready), 0);
        drive(1, 20, 1, 0, 0);
        step();
        $display("push 20 while full, no pop: cnt=%0d ovf=%0b", count, overflow);
        chk("full_drop_count", int'(count), 16);
        chk("full_drop_overflow", int'(overflow), 1);
        chk("full_drop_head", int'(out_var), 0);
        drive(1, 20, 1, 1, 0);
        #1;
        chk("full_pop_in_ready", int'(in_ready), 1);
        step();
        $display("push 20 while full, with pop: cnt=%0d head=%0d", count, out_var);
        chk("full_pop_count", int'(count), 16);
        chk("full_pop_head", int'(out_var), 1);
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 0, 0, 1, 0);
            #1;
            chk($sformatf("drain%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("drain%0d_var", i), int'(out_var), (i < DEPTH) ? i : 20);
            chk($sformatf("drain%0d_val", i), int'(out_val), (i < DEPTH) ? (i % 2) : 1);
            step();
        end
        chk("drained_count", int'(count), 0);

        // 40 distinct implications, out_ready toggling, pointer wrap
        drive(0, 0, 0, 0, 1);
        step();
        k = 0;
        mcount = 0;
        cyc = 0;
        while (cyc < 400 && (k < 40 || mcount > 0)) begin
            exp_pop = (cyc % 2 == 1) && (mcount > 0);
            exp_rdy = (mcount < DEPTH) || exp_pop;
            do_push = (k < 40) && exp_rdy;
            drive(do_push, 40 + k, 1'(k % 2), 1'(cyc % 2), 0);
            #1;
            chk($sformatf("wrap%0d_in_ready", cyc), int'(in_ready), int'(exp_rdy));
            if (exp_pop) begin
                $display("wrap pop: var=%0d val=%0b expect var=%0d val=%0b",
                         out_var, out_val, q_var[0], q_val[0]);
                chk($sformatf("wrap%0d_valid", cyc), int'(out_valid), 1);
                chk($sformatf("wrap%0d_var", cyc), int'(out_var), q_var[0]);
                chk($sformatf("wrap%0d_val", cyc), int'(out_val), int'(q_val[0]));
                void'(q_var.pop_front());
                void'(q_val.pop_front());
                mcount--;
            end
            if (do_push) begin
                q_var.push_back(40 + k);
                q_val.push_back(1'(k % 2));
                mcount++;
                k++;
            end
            step();
            chk($sformatf("wrap%0d_count", cyc), int'(count), mcount);
            cyc++;
        end
        chk("wrap_done", int'(k == 40 && mcount == 0), 1);
        idle();

        // Asynchronous reset mid-cycle with count=6 and conflict=1
        drive(0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 10 + i, 1, 0, 0);
            step();
        end
        drive(1, 10, 0, 0, 0);
        step();
        idle();
        chk("pre_rst_count", int'(count), 6);
        chk("pre_rst_conflict", int'(conflict), 1);
        #2 reset_n = 1'b0;
        #1;
        $display("async reset: cnt=%0d ov=%0b conf=%0b cvar=%0d ovf=%0b",
                 count, out_valid, conflict, conflict_var, overflow);
        chk("arst_count", int'(count), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_var", int'(out_var), 0);
        chk("arst_out_val", int'(out_val), 0);
        chk("arst_conflict", int'(conflict), 0);
        chk("arst_conflict_var", int'(conflict_var), 0);
        chk("arst_overflow", int'(overflow), 0);
        #1 reset_n = 1'b1;
        drive(1, 6, 1, 0, 0);
        step();
        chk("after_rst_count", int'(count), 1);
        chk("after_rst_head_var", int'(out_var), 6);
        chk("after_rst_head_val", int'(out_val), 1);
        chk("after_rst_conflict", int'(conflict), 0);
        drive(1, 10, 0, 0, 0);
        step();
        chk("after_rst_pend_clear", int'(count), 2);
        chk("after_rst_no_conflict", int'(conflict), 0);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
